// File: rtl/diff_window_if.sv
// Handshake and data bundle between a mismatch source / result consumer and diff_window_counter.
// Carries out_maxrun only when DIFF_WINDOW_RUNLEN_EN is defined.
interface diff_window_if #(
    parameter int CNT_W = 5
);
    logic             start;
    logic             in_valid;
    logic             in_diff;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             out_alarm;
    logic             overrun;
`ifdef DIFF_WINDOW_RUNLEN_EN
    logic [CNT_W-1:0] out_maxrun;
`endif

    // Result handshake: a result transfers on a cycle where out_valid & out_ready are both 1;
    // out_valid never drops and the result never changes until that cycle.
    modport master (
        output start, in_valid, in_diff, out_ready,
        input  busy, out_valid, out_count, out_alarm, overrun
`ifdef DIFF_WINDOW_RUNLEN_EN
        , input out_maxrun
`endif
    );

    modport slave (
        input  start, in_valid, in_diff, out_ready,
        output busy, out_valid, out_count, out_alarm, overrun
`ifdef DIFF_WINDOW_RUNLEN_EN
        , output out_maxrun
`endif
    );
endinterface

// File: rtl/diff_window_counter.sv
// Counts mismatch bits over a window of WINDOW valid samples and presents count + threshold alarm.
// Optional longest-run tracking (out_maxrun) is enabled by defining DIFF_WINDOW_RUNLEN_EN.
module diff_window_counter #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 5,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             areset,
    diff_window_if.slave     bus,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] samp_q, samp_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             alarm_q, alarm_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] samp_inc, miss_inc;
    logic             hit;

    assign samp_inc = samp_q + CNT_W'(1);
    assign miss_inc = miss_q + CNT_W'(bus.in_diff);
    assign hit      = (32'(miss_inc) >= THRESH);

`ifdef DIFF_WINDOW_RUNLEN_EN
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] maxout_q, maxout_d;
    logic [CNT_W-1:0] run_inc, max_new;

    // Gap cycles never reach this logic, so they neither extend nor break a run.
    assign run_inc = bus.in_diff ? (run_q + CNT_W'(1)) : '0;
    assign max_new = (run_inc > max_q) ? run_inc : max_q;
`endif

    always_comb begin
        state_d   = state_q;
        samp_d    = samp_q;
        miss_d    = miss_q;
        count_d   = count_q;
        alarm_d   = alarm_q;
        overrun_d = overrun_q;
`ifdef DIFF_WINDOW_RUNLEN_EN
        run_d     = run_q;
        max_d     = max_q;
        maxout_d  = maxout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_ACCUM;
                    samp_d    = '0;
                    miss_d    = '0;
                    overrun_d = 1'b0;
`ifdef DIFF_WINDOW_RUNLEN_EN
                    run_d     = '0;
                    max_d     = '0;
`endif
                end
            end
            S_ACCUM: begin
                if (bus.in_valid) begin
                    samp_d = samp_inc;
                    miss_d = miss_inc;
`ifdef DIFF_WINDOW_RUNLEN_EN
                    run_d  = run_inc;
                    max_d  = max_new;
`endif
                    if (samp_inc == LAST) begin
                        state_d  = S_HOLD;
                        count_d  = miss_inc;
                        alarm_d  = hit;
`ifdef DIFF_WINDOW_RUNLEN_EN
                        maxout_d = max_new;
`endif
                    end
                end
            end
            S_HOLD: begin
                if (bus.in_valid) overrun_d = 1'b1;
                if (bus.out_ready) begin
                    if (bus.start) begin
                        // Accepting a start wins over an overrun raised on the same cycle.
                        state_d   = S_ACCUM;
                        samp_d    = '0;
                        miss_d    = '0;
                        overrun_d = 1'b0;
`ifdef DIFF_WINDOW_RUNLEN_EN
                        run_d     = '0;
                        max_d     = '0;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q   <= S_IDLE;
            samp_q    <= '0;
            miss_q    <= '0;
            count_q   <= '0;
            alarm_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef DIFF_WINDOW_RUNLEN_EN
            run_q     <= '0;
            max_q     <= '0;
            maxout_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            samp_q    <= samp_d;
            miss_q    <= miss_d;
            count_q   <= count_d;
            alarm_q   <= alarm_d;
            overrun_q <= overrun_d;
`ifdef DIFF_WINDOW_RUNLEN_EN
            run_q     <= run_d;
            max_q     <= max_d;
            maxout_q  <= maxout_d;
`endif
        end
    end

    assign bus.busy      = (state_q == S_ACCUM);
    assign bus.out_valid = (state_q == S_HOLD);
    assign bus.out_count = count_q;
    assign bus.out_alarm = (state_q == S_HOLD) & alarm_q;
    assign bus.overrun   = overrun_q;
`ifdef DIFF_WINDOW_RUNLEN_EN
    assign bus.out_maxrun = maxout_q;
`endif
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_diff_window_counter.sv
// Directed self-checking bench for diff_window_counter (WINDOW=16, CNT_W=5, THRESH=4).
// Runs the run-length checks too when DIFF_WINDOW_RUNLEN_EN is defined.
module tb_diff_window_counter;
  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic [1:0] dbg_state;
  int         total = 0;
  int         bad = 0;

  diff_window_if #(.CNT_W(5)) bus ();

  diff_window_counter #(.WINDOW(16), .CNT_W(5), .THRESH(4)) dut (
    .clk       (clk),
    .areset    (areset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Apply inputs for one cycle; returns 1 time unit after the capturing edge.
  task automatic drive(input logic s, input logic v, input logic d, input logic r);
    bus.start     = s;
    bus.in_valid  = v;
    bus.in_diff   = d;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // 16 samples, sample i carries pat[i]; optional gap cycle (in_diff=1, in_valid=0) before each.
  task automatic run_window(input string tag, input logic [15:0] pat, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) drive(1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, pat[i], 1'b0);
      if (i == 14) check_eq({tag, "_valid_early"}, bus.out_valid, 0);
    end
    check_eq({tag, "_valid_rise"}, bus.out_valid, 1);
    check_eq({tag, "_busy_low"}, bus.busy, 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_diff = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_valid", bus.out_valid, 0);
    check_eq("rst_count", bus.out_count, 0);
    check_eq("rst_alarm", bus.out_alarm, 0);
    check_eq("rst_overrun", bus.overrun, 0);
    areset = 1'b0;

    // Samples in IDLE are ignored.
    repeat (20) drive(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("idle_valid", bus.out_valid, 0);
    check_eq("idle_overrun", bus.overrun, 0);
    check_eq("idle_busy", bus.busy, 0);

    // Basic window: mismatches on samples 1, 5, 9.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("basic_busy", bus.busy, 1);
    run_window("basic", 16'h0111, 1'b0);
    check_eq("basic_count", bus.out_count, 3);
    check_eq("basic_alarm", bus.out_alarm, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("basic_ack_valid", bus.out_valid, 0);
    check_eq("basic_ack_alarm", bus.out_alarm, 0);
    check_eq("basic_ack_state", dbg_state, 0);

    // Gapped input, six mismatches.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    run_window("gap", 16'h3C0C, 1'b1);
    check_eq("gap_count", bus.out_count, 6);
    check_eq("gap_alarm", bus.out_alarm, 1);
    check_eq("gap_overrun", bus.overrun, 0);

    // Backpressure with samples arriving in HOLD.
    repeat (10) drive(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("bp_valid", bus.out_valid, 1);
    check_eq("bp_count", bus.out_count, 6);
    check_eq("bp_alarm", bus.out_alarm, 1);
    check_eq("bp_overrun", bus.overrun, 1);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("b2b_busy", bus.busy, 1);
    check_eq("b2b_valid", bus.out_valid, 0);
    check_eq("b2b_overrun", bus.overrun, 0);
    run_window("b2b", 16'h0003, 1'b0);
    check_eq("b2b_count", bus.out_count, 2);
    check_eq("b2b_alarm", bus.out_alarm, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Exactly THRESH mismatches raises the alarm.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    run_window("thr", 16'hF000, 1'b0);
    check_eq("thr_count", bus.out_count, 4);
    check_eq("thr_alarm", bus.out_alarm, 1);
`ifdef DIFF_WINDOW_RUNLEN_EN
    check_eq("thr_maxrun", bus.out_maxrun, 4);
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a window.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (8) drive(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("mid_busy", bus.busy, 1);
    #3 areset = 1'b1;
    #1;
    check_eq("mid_rst_busy", bus.busy, 0);
    check_eq("mid_rst_valid", bus.out_valid, 0);
    check_eq("mid_rst_count", bus.out_count, 0);
    check_eq("mid_rst_state", dbg_state, 0);
    #2 areset = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    run_window("post", 16'h0000, 1'b0);
    check_eq("post_count", bus.out_count, 0);
    check_eq("post_alarm", bus.out_alarm, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // Full-scale window.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    run_window("full", 16'hFFFF, 1'b0);
    check_eq("full_count", bus.out_count, 16);
    check_eq("full_alarm", bus.out_alarm, 1);
`ifdef DIFF_WINDOW_RUNLEN_EN
    check_eq("full_maxrun", bus.out_maxrun, 16);
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef DIFF_WINDOW_RUNLEN_EN
    // Pattern 1,1,0,1,1,1,0 then nine zeros; gaps must not break runs.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    run_window("run", 16'h003B, 1'b1);
    check_eq("run_count", bus.out_count, 5);
    check_eq("run_maxrun", bus.out_maxrun, 3);
    check_eq("run_alarm", bus.out_alarm, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
